irq_queue: RTL and testbench
============================

Name: irq_queue

Overview:
- Multi-source interrupt event queue; generalises the single keyboard IRQ/intData latch into CHANNELS sources with a DEPTH-entry FIFO.
- Sits in fastClk domain between event producers (KeyboardReader, IR receiver, timers) and the rcpu irq/intData/turnOffIRQ interface.
- Events are no longer lost while the CPU services a previous one; every queued event carries its source channel id.

Parameters:
CHANNELS, 4, number of event sources (1..8)
SRC_W, 9, payload width per source
DATA_W, 16, intData width; must be >= SRC_W + CH_W, where CH_W = max(1, clog2(CHANNELS))
DEPTH, 8, FIFO entries; power of 2, >= 2

Ports:
fastClk  in  1  clock
rst  in  1  reset
srcValid  in  CHANNELS  per-channel event level, synchronous to fastClk; rising edge = one event
srcData  in  CHANNELS*SRC_W  payload; channel i occupies bits [i*SRC_W +: SRC_W]; sampled on the rising edge
chanEn  in  CHANNELS  per-channel enable mask
intEn  in  1  global CPU interrupt enable
ack  in  1  turnOffIRQ from the CPU (clk2 domain, asynchronous to fastClk)
clrOverflow  in  1  clears overflow
irq  out  1  interrupt request to the CPU
intData  out  DATA_W  FIFO head entry
count  out  clog2(DEPTH)+1  FIFO occupancy
overflow  out  1  sticky event-lost flag

Behaviour:
- Reset: rst is synchronous, active-high; clock is fastClk. On reset, irq=0, intData=0, count=0 and overflow=0. All srcValid history, pending latches, ack synchroniser flops and FIFO pointers also clear.
- Edge detect: rise[i] = srcValid[i] & ~prev[i]. prev is registered every cycle, independent of chanEn.
- Pending stage: one-deep latch per channel.
  - On rise[i] & chanEn[i], pend[i] is set and pendData[i] is captured from srcData.
  - If pend[i] is already set and is not being enqueued that same cycle, the new event is dropped, pend[i] keeps its old data, and overflow is set.
  - Clearing chanEn does not clear an existing pend[i].
- Arbiter: each cycle, the lowest-index set pend[i] is enqueued if the FIFO is not full, or is full and a pop occurs in the same cycle. That pend[i] clears. At most one enqueue per cycle. Other pending channels wait; there is no starvation limit.
- Entry format:
  - intData[DATA_W-1 -: CH_W] = channel index.
  - intData[SRC_W-1:0] = payload.
  - All bits in between are 0.
- Latency: srcValid rises before edge E0, so pend is set at E0. With an empty FIFO and no higher-priority pend, the entry is written at E1. intData, count and irq are valid after E1.
- irq = (count != 0) & intEn, registered. It drops on the cycle after intEn falls and re-asserts when intEn returns while entries remain. intData always shows the head regardless of intEn.
- Ack path:
  - 2-flop synchroniser, then edge detect: popReq = s2 & ~s3.
  - With ack sampled high at edge E0, the pop occurs at E2. The new head, count and irq are valid after E2.
  - Ack held high for many cycles pops exactly once.
  - popReq with an empty FIFO is ignored and does not set overflow.
- Simultaneous enqueue and pop: both occur, count is unchanged, and the full case is permitted.
- Full FIFO with no pop: pends are held (backpressure). Only a second event on an already-pending channel is lost.
- Overflow: sticky. If clrOverflow and a new drop occur in the same cycle, the set wins.
- Pointers wrap modulo DEPTH; count saturates at DEPTH by construction.
- rst asserted mid-operation discards all queued and pending events immediately at that edge.

Test Plan:
- Single event: channel 0, srcData=0x1A5, intEn=1 -> irq=1 after 2 edges, intData=0x01A5 (ch 0), count=1. Ack pulse -> irq=0 after 3 edges, count=0.
- Simultaneous rises on ch2 (0x033) and ch1 (0x044) -> ch1 dequeued first, intData=0x4044. After ack, intData=0x8033.
- Fill: 8 separate events on ch3 with no ack -> count=8. Ninth event -> pend held, count stays 8. Tenth event on ch3 -> overflow=1. One ack -> count=8 again as the held event enters.
- Long ack: ack held high 50 cycles with 3 entries queued -> exactly one pop, count=2. intEn=0 -> irq=0 and intData unchanged; intEn=1 -> irq=1.
- Masking and reset: chanEn[1]=0, rise on ch1 -> no enqueue, count=0. rst mid-operation with count=5 and overflow=1 -> all outputs 0 on the next cycle.

Source files
------------

// File: rtl/irq_queue.sv
// irq_queue: multi-source interrupt event queue.
//
// Up to CHANNELS event producers signal events with a rising edge on srcValid.
// Each event is parked in a one-deep pending latch for its channel. A
// fixed-priority arbiter (lowest channel index wins) moves one pending event
// per cycle into a DEPTH-entry FIFO. The FIFO head goes to the CPU as intData,
// tagged with its channel id. The CPU acknowledges from another clock domain
// through ack, which pops the head.
//
// Ports:
//   fastClk      clock
//   rst          synchronous, active-high reset
//   srcValid     per-channel event level; a rising edge is one event
//   srcData      per-channel payload, channel i at [i*SRC_W +: SRC_W]
//   chanEn       per-channel enable mask, applied when an event arrives
//   intEn        global CPU interrupt enable; gates irq only
//   ack          turnOffIRQ from the CPU, asynchronous to fastClk
//   clrOverflow  clears the sticky overflow flag
//   irq          registered interrupt request: (occupancy != 0) & intEn
//   intData      FIFO head {channel, zeros, payload}; 0 while the FIFO is empty
//   count        FIFO occupancy, 0..DEPTH
//   overflow     sticky flag, set when an event is dropped on a busy pending latch
module irq_queue #(
  parameter int CHANNELS = 4,
  parameter int SRC_W    = 9,
  parameter int DATA_W   = 16,
  parameter int DEPTH    = 8
) (
  input  logic                      fastClk,
  input  logic                      rst,
  input  logic [CHANNELS-1:0]       srcValid,
  input  logic [CHANNELS*SRC_W-1:0] srcData,
  input  logic [CHANNELS-1:0]       chanEn,
  input  logic                      intEn,
  input  logic                      ack,
  input  logic                      clrOverflow,
  output logic                      irq,
  output logic [DATA_W-1:0]         intData,
  output logic [$clog2(DEPTH):0]    count,
  output logic                      overflow
);

  localparam int CH_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam int PW   = $clog2(DEPTH);
  localparam logic [PW:0] FULL_CNT = (PW+1)'(DEPTH);

  // Control state
  logic [CHANNELS-1:0] prev;
  logic [CHANNELS-1:0] pend;
  logic                ackS1, ackS2, ackS3;
  logic [PW-1:0]       wrPtr, rdPtr;
  logic [PW:0]         cnt;

  // Data state (not reset; validity is tracked by pend and cnt)
  logic [SRC_W-1:0]    pendData [CHANNELS];
  logic [DATA_W-1:0]   mem [DEPTH];

  logic [CHANNELS-1:0] rise, take, enqSel, drop;
  logic                anyPend, full, empty, popReq, pop, enq;
  logic [CH_W-1:0]     selIdx;
  logic [DATA_W-1:0]   entry;
  logic [PW:0]         cntNext;

  // Stage 0: edge detect and enable mask
  assign rise = srcValid & ~prev;
  assign take = rise & chanEn;

  assign full   = (cnt == FULL_CNT);
  assign empty  = (cnt == '0);
  assign popReq = ackS2 & ~ackS3;
  assign pop    = popReq & ~empty;

  // Stage 1: priority arbiter, lowest pending index wins
  always_comb begin
    anyPend = 1'b0;
    selIdx  = '0;
    for (int i = CHANNELS-1; i >= 0; i--) begin
      if (pend[i]) begin
        anyPend = 1'b1;
        selIdx  = CH_W'(i);
      end
    end
  end

  // A full FIFO still accepts a write when the head leaves in the same cycle.
  assign enq = anyPend & (~full | pop);

  always_comb begin
    enqSel = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      enqSel[i] = enq && (selIdx == CH_W'(i));
    end
  end

  // An event is lost only if its channel is still occupied after this cycle.
  assign drop = take & pend & ~enqSel;

  always_comb begin
    entry                       = '0;
    entry[DATA_W-1 -: CH_W]     = selIdx;
    entry[SRC_W-1:0]            = pendData[selIdx];
  end

  always_comb begin
    cntNext = cnt;
    case ({enq, pop})
      2'b10:   cntNext = cnt + 1'b1;
      2'b01:   cntNext = cnt - 1'b1;
      default: cntNext = cnt;
    endcase
  end

  always_ff @(posedge fastClk) begin
    if (rst) begin
      prev     <= '0;
      pend     <= '0;
      ackS1    <= 1'b0;
      ackS2    <= 1'b0;
      ackS3    <= 1'b0;
      wrPtr    <= '0;
      rdPtr    <= '0;
      cnt      <= '0;
      irq      <= 1'b0;
      overflow <= 1'b0;
    end else begin
      prev  <= srcValid;
      pend  <= (pend & ~enqSel) | take;
      ackS1 <= ack;
      ackS2 <= ackS1;
      ackS3 <= ackS2;
      if (enq) wrPtr <= wrPtr + 1'b1;
      if (pop) rdPtr <= rdPtr + 1'b1;
      cnt   <= cntNext;
      // Computed from the next occupancy so irq lines up with count and intData.
      irq   <= (cntNext != '0) & intEn;
      if (|drop)            overflow <= 1'b1;
      else if (clrOverflow) overflow <= 1'b0;
    end
  end

  // Stage 1 data: pending payload capture and FIFO write
  always_ff @(posedge fastClk) begin
    for (int i = 0; i < CHANNELS; i++) begin
      if (take[i] && !drop[i]) pendData[i] <= srcData[i*SRC_W +: SRC_W];
    end
    if (enq) mem[wrPtr] <= entry;
  end

  // Stage 2: head presentation
  assign intData = empty ? '0 : mem[rdPtr];
  assign count   = cnt;

endmodule

// File: tb/tb_irq_queue.sv
module tb_irq_queue;

  logic        fastClk = 1'b0;
  logic        rst;
  logic [3:0]  srcValid;
  logic [35:0] srcData;
  logic [3:0]  chanEn;
  logic        intEn;
  logic        ack;
  logic        clrOverflow;
  logic        irq;
  logic [15:0] intData;
  logic [3:0]  count;
  logic        overflow;

  int nPass = 0;
  int nTotal = 0;

  irq_queue #(.CHANNELS(4), .SRC_W(9), .DATA_W(16), .DEPTH(8)) dut (
    .fastClk(fastClk), .rst(rst), .srcValid(srcValid), .srcData(srcData),
    .chanEn(chanEn), .intEn(intEn), .ack(ack), .clrOverflow(clrOverflow),
    .irq(irq), .intData(intData), .count(count), .overflow(overflow)
  );

  always #5 fastClk = ~fastClk;

  typedef struct {
    logic        rst;
    logic [3:0]  sv;
    logic [35:0] sd;
    logic [3:0]  en;
    logic        ie;
    logic        ack;
    logic        clr;
    logic        xIrq;
    logic [15:0] xData;
    logic [3:0]  xCnt;
    logic        xOv;
  } vec_t;

  vec_t tbl[$];

  function automatic logic [35:0] pk(input int ch, input logic [8:0] d);
    logic [35:0] r;
    r = '0;
    r[ch*9 +: 9] = d;
    return r;
  endfunction

  function automatic vec_t mk(input logic r, input logic [3:0] sv, input logic [35:0] sd,
                              input logic [3:0] en, input logic ie, input logic a,
                              input logic c, input logic xi, input logic [15:0] xd,
                              input logic [3:0] xc, input logic xo);
    vec_t v;
    v.rst = r; v.sv = sv; v.sd = sd; v.en = en; v.ie = ie; v.ack = a; v.clr = c;
    v.xIrq = xi; v.xData = xd; v.xCnt = xc; v.xOv = xo;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nTotal++;
    if (act === exp) nPass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge fastClk);
    #1;
  endtask

  task automatic pulse(input int ch, input logic [8:0] d);
    srcValid[ch] = 1'b1;
    srcData = pk(ch, d);
    tick();
    srcValid[ch] = 1'b0;
    tick();
  endtask

  task automatic ackPulse();
    ack = 1'b1; tick();
    ack = 1'b0; tick();
    tick();
  endtask

  initial begin
    rst = 1'b1; srcValid = '0; srcData = '0; chanEn = 4'hF;
    intEn = 1'b1; ack = 1'b0; clrOverflow = 1'b0;

    //           rst  sv     sd                          en     ie ack clr  irq data     cnt ov
    tbl.push_back(mk(1, 4'h0, '0,                         4'hF, 1, 0, 0,   0, 16'h0000, 0, 0));
    tbl.push_back(mk(0, 4'h0, '0,                         4'hF, 1, 0, 0,   0, 16'h0000, 0, 0));
    // single event on ch0
    tbl.push_back(mk(0, 4'h1, pk(0, 9'h1A5),              4'hF, 1, 0, 0,   0, 16'h0000, 0, 0));
    tbl.push_back(mk(0, 4'h1, pk(0, 9'h1A5),              4'hF, 1, 0, 0,   1, 16'h01A5, 1, 0));
    tbl.push_back(mk(0, 4'h0, '0,                         4'hF, 1, 1, 0,   1, 16'h01A5, 1, 0));
    tbl.push_back(mk(0, 4'h0, '0,                         4'hF, 1, 0, 0,   1, 16'h01A5, 1, 0));
    tbl.push_back(mk(0, 4'h0, '0,                         4'hF, 1, 0, 0,   0, 16'h0000, 0, 0));
    // simultaneous rises on ch1 and ch2
    tbl.push_back(mk(0, 4'h6, pk(1, 9'h044) | pk(2, 9'h033), 4'hF, 1, 0, 0, 0, 16'h0000, 0, 0));
    tbl.push_back(mk(0, 4'h0, '0,                         4'hF, 1, 0, 0,   1, 16'h4044, 1, 0));
    tbl.push_back(mk(0, 4'h0, '0,                         4'hF, 1, 0, 0,   1, 16'h4044, 2, 0));
    tbl.push_back(mk(0, 4'h0, '0,                         4'hF, 1, 1, 0,   1, 16'h4044, 2, 0));
    tbl.push_back(mk(0, 4'h0, '0,                         4'hF, 1, 0, 0,   1, 16'h4044, 2, 0));
    tbl.push_back(mk(0, 4'h0, '0,                         4'hF, 1, 0, 0,   1, 16'h8033, 1, 0));
    tbl.push_back(mk(0, 4'h0, '0,                         4'hF, 1, 1, 0,   1, 16'h8033, 1, 0));
    tbl.push_back(mk(0, 4'h0, '0,                         4'hF, 1, 0, 0,   1, 16'h8033, 1, 0));
    tbl.push_back(mk(0, 4'h0, '0,                         4'hF, 1, 0, 0,   0, 16'h0000, 0, 0));
    // masked channel: no enqueue
    tbl.push_back(mk(0, 4'h2, pk(1, 9'h0AA),              4'hD, 1, 0, 0,   0, 16'h0000, 0, 0));
    tbl.push_back(mk(0, 4'h2, pk(1, 9'h0AA),              4'hD, 1, 0, 0,   0, 16'h0000, 0, 0));
    tbl.push_back(mk(0, 4'h0, '0,                         4'hF, 1, 0, 0,   0, 16'h0000, 0, 0));
    // ack on empty FIFO is ignored
    tbl.push_back(mk(0, 4'h0, '0,                         4'hF, 1, 1, 0,   0, 16'h0000, 0, 0));
    tbl.push_back(mk(0, 4'h0, '0,                         4'hF, 1, 0, 0,   0, 16'h0000, 0, 0));
    tbl.push_back(mk(0, 4'h0, '0,                         4'hF, 1, 0, 0,   0, 16'h0000, 0, 0));
    tbl.push_back(mk(0, 4'h0, '0,                         4'hF, 1, 0, 0,   0, 16'h0000, 0, 0));

    for (int i = 0; i < tbl.size(); i++) begin
      rst = tbl[i].rst; srcValid = tbl[i].sv; srcData = tbl[i].sd; chanEn = tbl[i].en;
      intEn = tbl[i].ie; ack = tbl[i].ack; clrOverflow = tbl[i].clr;
      tick();
      chk($sformatf("vec%0d_irq", i),  32'(irq),      32'(tbl[i].xIrq));
      chk($sformatf("vec%0d_data", i), 32'(intData),  32'(tbl[i].xData));
      chk($sformatf("vec%0d_cnt", i),  32'(count),    32'(tbl[i].xCnt));
      chk($sformatf("vec%0d_ov", i),   32'(overflow), 32'(tbl[i].xOv));
    end

    // Fill, backpressure, drop on busy pending latch
    srcValid = '0; chanEn = 4'hF; intEn = 1'b1; ack = 1'b0; clrOverflow = 1'b0;
    for (int k = 0; k < 8; k++) pulse(3, 9'(k));
    chk("fill_cnt", 32'(count), 32'd8);
    chk("fill_head", 32'(intData), 32'hC000);
    chk("fill_irq", 32'(irq), 32'd1);
    pulse(3, 9'h100);
    chk("held_cnt", 32'(count), 32'd8);
    chk("held_ov", 32'(overflow), 32'd0);
    pulse(3, 9'h155);
    chk("drop_ov", 32'(overflow), 32'd1);
    chk("drop_cnt", 32'(count), 32'd8);
    ack = 1'b1; tick();
    ack = 1'b0; tick();
    chk("prepop_cnt", 32'(count), 32'd8);
    tick();
    chk("fullswap_cnt", 32'(count), 32'd8);
    chk("fullswap_head", 32'(intData), 32'hC001);
    for (int k = 0; k < 7; k++) ackPulse();
    chk("drain_cnt", 32'(count), 32'd1);
    chk("drain_kept_old", 32'(intData), 32'hC100);
    clrOverflow = 1'b1; tick();
    clrOverflow = 1'b0;
    chk("clr_ov", 32'(overflow), 32'd0);

    // Long ack pops once; intEn gates irq only
    rst = 1'b1; tick(); rst = 1'b0;
    pulse(0, 9'h001); pulse(0, 9'h002); pulse(0, 9'h003);
    chk("long_pre_cnt", 32'(count), 32'd3);
    ack = 1'b1;
    repeat (50) tick();
    ack = 1'b0; tick();
    chk("long_cnt", 32'(count), 32'd2);
    chk("long_head", 32'(intData), 32'h0002);
    intEn = 1'b0; tick();
    chk("inten0_irq", 32'(irq), 32'd0);
    chk("inten0_data", 32'(intData), 32'h0002);
    intEn = 1'b1; tick();
    chk("inten1_irq", 32'(irq), 32'd1);

    // Drop with simultaneous clrOverflow (set wins), then reset mid-operation
    rst = 1'b1; tick(); rst = 1'b0;
    srcValid = 4'h7; srcData = pk(0, 9'h011) | pk(1, 9'h022) | pk(2, 9'h033); tick();
    srcValid = 4'h0; tick();
    srcValid = 4'h4; clrOverflow = 1'b1; tick();
    chk("setwins_ov", 32'(overflow), 32'd1);
    chk("setwins_cnt", 32'(count), 32'd2);
    srcValid = 4'h0; clrOverflow = 1'b0; tick();
    chk("three_cnt", 32'(count), 32'd3);
    pulse(0, 9'h044); pulse(1, 9'h055);
    chk("five_cnt", 32'(count), 32'd5);
    srcValid = 4'h8; srcData = pk(3, 9'h066); tick();
    rst = 1'b1; tick();
    chk("rst_irq", 32'(irq), 32'd0);
    chk("rst_data", 32'(intData), 32'h0000);
    chk("rst_cnt", 32'(count), 32'd0);
    chk("rst_ov", 32'(overflow), 32'd0);
    rst = 1'b0; srcValid = 4'h0; tick(); tick();
    chk("post_rst_cnt", 32'(count), 32'd0);
    chk("post_rst_irq", 32'(irq), 32'd0);

    $display("%0d/%0d checks passed", nPass, nTotal);
    $finish;
  end

endmodule
